// File: rtl/ir_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ir_ctrl_pkg
// Description : Shared types and constants for the IR fetch controller.
//               Holds the fetch FSM state encoding and the IR FunSel codes.
// Revision    : 1.0  initial release
// ============================================================================
package ir_ctrl_pkg;

    // Fetch FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        LO    = 3'd2,
        HI    = 3'd3,
        VALID = 3'd4,
        ERR   = 3'd5
    } state_t;

    // IR FunSel codes. The controller only ever drives CLR and LOAD;
    // DEC and INC are listed so the full IR encoding lives in one place.
    localparam logic [1:0] FS_CLR  = 2'b00;
    localparam logic [1:0] FS_LOAD = 2'b01;
    localparam logic [1:0] FS_DEC  = 2'b10;
    localparam logic [1:0] FS_INC  = 2'b11;

endpackage : ir_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_timer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_timer
// Description : Memory wait-cycle counter for the IR fetch controller.
//               Counts consecutive cycles in which i_count is high and
//               raises o_expire combinationally on the TIMEOUT_CYCLES-th
//               such cycle. Any cycle with i_count low clears the count.
// Ports       : clk      - clock
//               rst_n    - asynchronous active-low reset
//               i_count  - this cycle is a wait cycle
//               o_expire - this wait cycle is the TIMEOUT_CYCLES-th in a row
// Revision    : 1.0  initial release
// ============================================================================
module fetch_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_count,
    output logic o_expire
);

    // Counter only needs to hold 0 .. TIMEOUT_CYCLES-1
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] c_last = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    assign o_expire = i_count && (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_count && !o_expire) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            // Cleared on accepted byte, flush, leaving LO/HI, or expiry
            r_cnt <= '0;
        end
    end

endmodule : fetch_timer
`default_nettype wire

// File: rtl/ir_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ir_fetch_ctrl
// Description : Two-byte instruction fetch controller. Clears IR, reads a
//               low and a high byte from memory into IR, then holds the
//               instruction valid until decode acknowledges it.
//               Optional memory timeout enabled by macro IR_FETCH_TIMEOUT_EN.
// Ports       : clk, rst_n          - clock, async active-low reset
//               i_fetch_en          - request continuous fetch
//               i_flush             - abort fetch, back to IDLE, clear err
//               o_mem_req           - byte read request
//               i_mem_ready/i_mem_data - memory byte handshake
//               o_ir_i/o_ir_funsel/o_ir_lh/o_ir_en - IR register controls
//               o_pc_inc            - PC increment pulse per accepted byte
//               o_instr_valid/i_instr_ack - instruction handshake to decode
//               o_fetch_cnt         - completed instruction count (wraps)
//               o_err               - sticky memory timeout flag
// Revision    : 1.0  initial release
// ============================================================================
module ir_fetch_ctrl
    import ir_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_fetch_en,
    input  logic             i_flush,
    output logic             o_mem_req,
    input  logic             i_mem_ready,
    input  logic [7:0]       i_mem_data,
    output logic [7:0]       o_ir_i,
    output logic [1:0]       o_ir_funsel,
    output logic             o_ir_lh,
    output logic             o_ir_en,
    output logic             o_pc_inc,
    output logic             o_instr_valid,
    input  logic             i_instr_ack,
    output logic [CNT_W-1:0] o_fetch_cnt,
    output logic             o_err
);

    state_t           r_state;
    logic             r_mem_req;
    logic             r_instr_valid;
    logic             r_err;
    logic [CNT_W-1:0] r_fetch_cnt;

    logic w_in_fetch;
    logic w_accept;
    logic w_clear_ir;
    logic w_timeout;

    // A byte is accepted only while requesting and not being flushed, so the
    // IR write and PC increment land on the same edge as the state change.
    assign w_in_fetch = (r_state == LO) || (r_state == HI);
    assign w_accept   = w_in_fetch && i_mem_ready && !i_flush;
    assign w_clear_ir = (r_state == CLR) && !i_flush;

    assign o_ir_en     = w_accept || w_clear_ir;
    assign o_ir_funsel = w_accept ? FS_LOAD : FS_CLR;
    assign o_ir_lh     = w_accept && (r_state == HI);
    assign o_ir_i      = w_accept ? i_mem_data : 8'h00;
    assign o_pc_inc    = w_accept;

    assign o_mem_req     = r_mem_req;
    assign o_instr_valid = r_instr_valid;
    assign o_err         = r_err;
    assign o_fetch_cnt   = r_fetch_cnt;

`ifdef IR_FETCH_TIMEOUT_EN
    fetch_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fetch_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_count  (w_in_fetch && !i_mem_ready && !i_flush),
        .o_expire (w_timeout)
    );
`else
    // Without the timeout option LO/HI wait forever and ERR is unreachable
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_mem_req     <= 1'b0;
            r_instr_valid <= 1'b0;
            r_err         <= 1'b0;
            r_fetch_cnt   <= '0;
        end else if (i_flush) begin
            // Flush outranks every other event; count is preserved
            r_state       <= IDLE;
            r_mem_req     <= 1'b0;
            r_instr_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_fetch_en) begin
                        r_state <= CLR;
                    end
                end
                CLR: begin
                    r_state   <= LO;
                    r_mem_req <= 1'b1;
                end
                LO: begin
                    if (i_mem_ready) begin
                        r_state <= HI;
                    end else if (w_timeout) begin
                        r_state   <= ERR;
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                    end
                end
                HI: begin
                    if (i_mem_ready) begin
                        r_state       <= VALID;
                        r_mem_req     <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end else if (w_timeout) begin
                        r_state   <= ERR;
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                    end
                end
                VALID: begin
                    if (i_instr_ack) begin
                        r_fetch_cnt   <= r_fetch_cnt + CNT_W'(1);
                        r_instr_valid <= 1'b0;
                        r_state       <= i_fetch_en ? CLR : IDLE;
                    end
                end
                ERR: begin
                    // Held until flush or reset
                    r_state <= ERR;
                end
                default: begin
                    r_state       <= IDLE;
                    r_mem_req     <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_err         <= 1'b0;
                end
            endcase
        end
    end

endmodule : ir_fetch_ctrl
`default_nettype wire

// File: tb/tb_ir_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ir_fetch_ctrl
// Description : Self-checking bench for ir_fetch_ctrl. A transaction-level
//               model (bytes collected so far, busy/clear/error flags)
//               predicts every output each cycle; directed scenarios add
//               hand-computed checks on the resulting IR value, PC pulses,
//               latency, counter wrap and reset behaviour.
//               Honours macro IR_FETCH_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ir_fetch_ctrl;

    localparam int TO = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_en = 1'b0;
    logic          flush = 1'b0;
    logic          mem_ready = 1'b0;
    logic [7:0]    mem_data = 8'h00;
    logic          instr_ack = 1'b0;
    logic          mem_req;
    logic [7:0]    ir_i;
    logic [1:0]    ir_funsel;
    logic          ir_lh;
    logic          ir_en;
    logic          pc_inc;
    logic          instr_valid;
    logic [CW-1:0] fetch_cnt;
    logic          err;

    always #5 clk = ~clk;

    ir_fetch_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_fetch_en    (fetch_en),
        .i_flush       (flush),
        .o_mem_req     (mem_req),
        .i_mem_ready   (mem_ready),
        .i_mem_data    (mem_data),
        .o_ir_i        (ir_i),
        .o_ir_funsel   (ir_funsel),
        .o_ir_lh       (ir_lh),
        .o_ir_en       (ir_en),
        .o_pc_inc      (pc_inc),
        .o_instr_valid (instr_valid),
        .i_instr_ack   (instr_ack),
        .o_fetch_cnt   (fetch_cnt),
        .o_err         (err)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int pc_count = 0;
    logic [15:0] ir_reg = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) cyc++;

    // IR register emulation driven by the DUT's IR controls
    always @(posedge clk) begin
        if (ir_en) begin
            case (ir_funsel)
                2'b00: ir_reg = 16'h0000;
                2'b01: if (ir_lh) ir_reg[15:8] = ir_i; else ir_reg[7:0] = ir_i;
                2'b10: ir_reg = ir_reg - 16'd1;
                default: ir_reg = ir_reg + 16'd1;
            endcase
        end
    end

    // Transaction-level model
    bit          m_busy;
    bit          m_clr;
    bit          m_err;
    int          m_nb;
    int          m_wait;
    logic [CW-1:0] m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_clr = 0; m_err = 0; m_nb = 0; m_wait = 0; m_cnt = '0;
        end else if (flush) begin
            m_busy = 0; m_clr = 0; m_err = 0; m_nb = 0; m_wait = 0;
        end else if (m_err) begin
            m_err = 1;
        end else if (!m_busy) begin
            if (fetch_en) begin
                m_busy = 1; m_clr = 1; m_nb = 0;
            end
        end else if (m_clr) begin
            m_clr = 0;
        end else if (m_nb < 2) begin
            if (mem_ready) begin
                m_nb++;
                m_wait = 0;
            end
`ifdef IR_FETCH_TIMEOUT_EN
            else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_err = 1; m_busy = 0; m_wait = 0;
                end
            end
`endif
        end else if (instr_ack) begin
            m_cnt = m_cnt + 1'b1;
            if (fetch_en) begin
                m_clr = 1; m_nb = 0;
            end else begin
                m_busy = 0;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin : cmp
        bit e_req, e_acc, e_clr;
        if (rst_n) begin
            e_req = m_busy && !m_clr && (m_nb < 2);
            e_acc = e_req && mem_ready && !flush;
            e_clr = m_busy && m_clr && !flush;
            check("mem_req",     mem_req,     e_req);
            check("ir_en",       ir_en,       e_acc || e_clr);
            check("ir_funsel",   ir_funsel,   e_acc ? 2'b01 : 2'b00);
            check("ir_lh",       ir_lh,       e_acc && (m_nb == 1));
            check("ir_I",        ir_i,        e_acc ? mem_data : 8'h00);
            check("pc_inc",      pc_inc,      e_acc);
            check("instr_valid", instr_valid, m_busy && (m_nb == 2));
            check("fetch_cnt",   fetch_cnt,   m_cnt);
            check("err",         err,         m_err);
            if (pc_inc) pc_count++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int max);
        int k = 0;
        while (!mem_req && k < max) begin tick(); k++; end
        check("wait_mem_req", mem_req, 1'b1);
    endtask

    task automatic serve(input logic [7:0] d, input int dly);
        wait_req(50);
        if (dly > 0) tick(dly);
        mem_ready = 1'b1;
        mem_data  = d;
        tick();
        mem_ready = 1'b0;
        mem_data  = 8'h00;
    endtask

    task automatic wait_valid(input int max);
        int k = 0;
        while (!instr_valid && k < max) begin tick(); k++; end
        check("wait_instr_valid", instr_valid, 1'b1);
    endtask

    task automatic ack();
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
    endtask

    task automatic start_fetch();
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;   // dropping fetch_en in CLR must not abort
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int k;
        // Reset state
        tick(3);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_valid",   instr_valid, 1'b0);
        check("rst_cnt",     fetch_cnt, 8'd0);
        check("rst_err",     err, 1'b0);
        check("rst_ir_en",   ir_en, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // Zero-wait fetch 0x34, 0x12
        pc_count = 0;
        t0 = cyc;
        start_fetch();
        serve(8'h34, 0);
        serve(8'h12, 0);
        wait_valid(20);
        check("valid_latency", cyc - t0, 4);
        ack();
        check("ir_1234",   ir_reg, 16'h1234);
        check("pc_pulses", pc_count, 2);
        check("cnt_1",     fetch_cnt, 8'd1);
        tick(2);

        // Three wait cycles per byte
        pc_count = 0;
        start_fetch();
        serve(8'hCD, 3);
        serve(8'hAB, 3);
        wait_valid(20);
        ack();
        check("ir_abcd",      ir_reg, 16'hABCD);
        check("pc_pulses_w",  pc_count, 2);
        check("cnt_2",        fetch_cnt, 8'd2);
        tick(2);

        // Flush together with HI-byte mem_ready
        pc_count = 0;
        start_fetch();
        serve(8'h78, 0);
        mem_ready = 1'b1;
        mem_data  = 8'h56;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        mem_ready = 1'b0;
        mem_data  = 8'h00;
        check("flush_ir",      ir_reg, 16'h0078);
        check("flush_pc",      pc_count, 1);
        check("flush_req",     mem_req, 1'b0);
        tick(5);
        check("flush_valid",   instr_valid, 1'b0);
        check("flush_cnt",     fetch_cnt, 8'd2);

        // ack and mem_ready outside their states are ignored
        instr_ack = 1'b1;
        mem_ready = 1'b1;
        tick(4);
        instr_ack = 1'b0;
        mem_ready = 1'b0;
        check("ign_cnt", fetch_cnt, 8'd2);
        check("ign_pc",  pc_count, 1);

        // Memory never answers
        start_fetch();
        wait_req(10);
`ifdef IR_FETCH_TIMEOUT_EN
        tick(TO - 1);
        check("to_err_before", err, 1'b0);
        check("to_req_before", mem_req, 1'b1);
        tick();
        check("to_err",     err, 1'b1);
        check("to_req_off", mem_req, 1'b0);
        tick(3);
        check("to_err_sticky", err, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("to_err_clr", err, 1'b0);
`else
        tick(40);
        check("nto_err", err, 1'b0);
        check("nto_req", mem_req, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("nto_flush_req", mem_req, 1'b0);
`endif
        tick(2);

        // Reset pulse in LO with mem_ready high
        start_fetch();
        wait_req(10);
        mem_ready = 1'b1;
        mem_data  = 8'h99;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_req", mem_req, 1'b0);
        check("arst_ir_en",   ir_en, 1'b0);
        check("arst_pc_inc",  pc_inc, 1'b0);
        check("arst_ir_I",    ir_i, 8'h00);
        check("arst_valid",   instr_valid, 1'b0);
        check("arst_cnt",     fetch_cnt, 8'd0);
        check("arst_err",     err, 1'b0);
        mem_ready = 1'b0;
        mem_data  = 8'h00;
        tick();
        rst_n = 1'b1;
        pc_count = 0;
        tick(5);
        check("arst_no_pc", pc_count, 0);

        // 256 back-to-back fetches wrap the counter
        fetch_en  = 1'b1;
        mem_ready = 1'b1;
        mem_data  = 8'h5A;
        instr_ack = 1'b1;
        k = 0;
        while (fetch_cnt != 8'd255 && k < 1100) begin tick(); k++; end
        check("cnt_255", fetch_cnt, 8'd255);
        k = 0;
        while (fetch_cnt != 8'd0 && k < 8) begin tick(); k++; end
        check("cnt_wrap", fetch_cnt, 8'd0);
        check("wrap_spacing", k, 4);
        fetch_en  = 1'b0;
        mem_ready = 1'b0;
        instr_ack = 1'b0;
        tick(6);
        check("end_valid", instr_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ir_fetch_ctrl
`default_nettype wire
